// File: rtl/dense_sequencer.sv
// Sequencer for the dense / 1x1-conv engine array: clear, operand feed,
// latency drain, shifter settle, then a valid/ready result handshake.
module dense_sequencer #(
    parameter int AddrBits    = 10,
    parameter int ShiftBits   = 6,
    parameter int ReadLatency = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 accum_mode_i,
    input  logic [AddrBits:0]    input_len_i,
    input  logic [ShiftBits-1:0] shift_i,
    output logic                 busy_o,
    output logic                 rd_en_o,
    output logic [AddrBits-1:0]  addr_o,
    output logic                 mac_clear_o,
    output logic                 mac_en_o,
    output logic                 accum_o,
    output logic [ShiftBits-1:0] shift_o,
    output logic                 shift_active_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 done_o
);

    localparam int LW = AddrBits + 1;
    localparam logic [LW-1:0] MaxLen = {1'b1, {AddrBits{1'b0}}};
    localparam logic [LW-1:0] One = 1;
    localparam logic [ShiftBits-1:0] SOne = 1;
    localparam logic [LW-1:0] DrainLast = LW'(ReadLatency > 0 ? ReadLatency - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_SHIFT, S_OUTPUT
    } state_e;

    state_e               state_q, state_d, post_st;
    logic [LW-1:0]        cnt_q, cnt_d;
    logic [LW-1:0]        len_q, len_d;
    logic [ShiftBits-1:0] scnt_q, scnt_d;
    logic [ShiftBits-1:0] shift_q, shift_d;
    logic                 accum_q, accum_d;
    logic                 busy_q, busy_d;
    logic                 rd_en_q, rd_en_d;
    logic [AddrBits-1:0]  addr_q, addr_d;
    logic                 clear_q, clear_d;
    logic                 sact_q, sact_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        scnt_d  = scnt_q;
        shift_d = shift_q;
        accum_d = accum_q;
        done_d  = 1'b0;
        post_st = (shift_q != '0) ? S_SHIFT : S_OUTPUT;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CLEAR;
                    len_d   = (input_len_i > MaxLen) ? MaxLen : input_len_i;
                    accum_d = accum_mode_i;
                    shift_d = shift_i;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                scnt_d  = '0;
                state_d = (len_q != '0) ? S_FEED : S_OUTPUT;
            end
            S_FEED: begin
                if (cnt_q + One == len_q) begin
                    cnt_d   = '0;
                    state_d = (ReadLatency > 0) ? S_DRAIN : post_st;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DrainLast) begin
                    state_d = post_st;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            S_SHIFT: begin
                if (scnt_q == shift_q - SOne) begin
                    state_d = S_OUTPUT;
                end else begin
                    scnt_d = scnt_q + SOne;
                end
            end
            S_OUTPUT: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are decoded from the next state so they come straight off flops.
        busy_d  = (state_d != S_IDLE);
        rd_en_d = (state_d == S_FEED);
        addr_d  = rd_en_d ? cnt_d[AddrBits-1:0] : '0;
        clear_d = (state_d == S_CLEAR);
        sact_d  = (state_d == S_SHIFT);
        valid_d = (state_d == S_OUTPUT);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            scnt_q  <= '0;
            shift_q <= '0;
            accum_q <= 1'b0;
            busy_q  <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            clear_q <= 1'b0;
            sact_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            scnt_q  <= scnt_d;
            shift_q <= shift_d;
            accum_q <= accum_d;
            busy_q  <= busy_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            clear_q <= clear_d;
            sact_q  <= sact_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    generate
        if (ReadLatency == 0) begin : g_nodly
            assign mac_en_o = rd_en_q;
        end else begin : g_dly
            logic [ReadLatency-1:0] dly_q, dly_d;
            logic [ReadLatency:0]   dly_ext;
            assign dly_ext  = {dly_q, rd_en_q};
            assign dly_d    = dly_ext[ReadLatency-1:0];
            assign mac_en_o = dly_ext[ReadLatency];
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= dly_d;
                end
            end
        end
    endgenerate

    assign busy_o         = busy_q;
    assign rd_en_o        = rd_en_q;
    assign addr_o         = addr_q;
    assign mac_clear_o    = clear_q;
    assign accum_o        = accum_q;
    assign shift_o        = shift_q;
    assign shift_active_o = sact_q;
    assign out_valid_o    = valid_q;
    assign done_o         = done_q;

endmodule
